// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, M-field bit positions
// and the value loaded into DM_out when a read times out.
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int MEMREAD  = 1;
   localparam int MEMWRITE = 0;

   localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles spent waiting for mem_ready.
// expired is high during the MAX_WAIT-th waiting cycle.
module mem_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   logic [CW-1:0] count;

   assign expired = (count == CW'(MAX_WAIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM load/store controls into a handshaked memory access,
// freezing the upstream pipeline until the access completes, errors or times out.
module mem_access_stage
   import pipeline_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  M,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] DM_out,
   output logic        stall,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   state_t state;
   logic   rd_op;
   logic   expired;
   logic   misaligned;

   assign misaligned = (address[1:0] != 2'b00);

   // Stall must rise in the same cycle a request appears, so it cannot be registered.
   assign stall = (state == ACCESS) || ((state == IDLE) && (M != 2'b00));

   // Held clear outside ACCESS, so every access starts counting from zero.
   mem_wait_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != ACCESS),
      .enable  ((state == ACCESS) && !mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         DM_out    <= '0;
         bus_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_op     <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (M != 2'b00) begin
                  if (misaligned) begin
                     bus_err <= 1'b1;
                     state   <= DONE;
                  end else begin
                     mem_addr  <= {address[31:2], 2'b00};
                     mem_wdata <= writeData;
                     mem_we    <= M[MEMWRITE];
                     rd_op     <= M[MEMREAD] & ~M[MEMWRITE];
                     mem_req   <= 1'b1;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  if (rd_op) DM_out <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= DONE;
               end else if (expired) begin
                  if (rd_op) DM_out <= TIMEOUT_DATA;
                  bus_err <= 1'b1;
                  mem_req <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed transactions push expected completions,
// a monitor pops them whenever stall falls.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  M;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] DM_out;
   logic        stall;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   typedef struct {
      string       name;
      logic [31:0] dm;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   completions = 0;
   int   c0;

   mem_access_stage #(.MAX_WAIT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .M         (M),
      .address   (address),
      .writeData (writeData),
      .DM_out    (DM_out),
      .stall     (stall),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd);
      M         = m;
      address   = a;
      writeData = wd;
   endtask

   task automatic expectCompletion(input string name, input logic [31:0] dm, input logic err);
      exp_t e;
      e.name = name;
      e.dm   = dm;
      e.err  = err;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " DM_out"}, DM_out, 32'h0);
      checkOutput({tag, " stall"}, {31'b0, stall}, 32'h0);
      checkOutput({tag, " bus_err"}, {31'b0, bus_err}, 32'h0);
      checkOutput({tag, " mem_req"}, {31'b0, mem_req}, 32'h0);
      checkOutput({tag, " mem_we"}, {31'b0, mem_we}, 32'h0);
      checkOutput({tag, " mem_addr"}, mem_addr, 32'h0);
      checkOutput({tag, " mem_wdata"}, mem_wdata, 32'h0);
   endtask

   // A transaction is complete on the cycle stall drops outside reset.
   initial begin
      logic prev_stall;
      exp_t e;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && prev_stall && !stall) begin
            completions++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected completion: got DM_out %h bus_err %b, expected none", DM_out, bus_err);
            end else begin
               e = sb.pop_front();
               checkOutput({e.name, " DM_out"}, DM_out, e.dm);
               checkOutput({e.name, " bus_err"}, {31'b0, bus_err}, {31'b0, e.err});
               checkOutput({e.name, " mem_req"}, {31'b0, mem_req}, 32'h0);
            end
         end
         prev_stall = stall;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion of the run");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      applyStimulus(2'b00, 32'h0, 32'h0);
      #2;
      checkResetOutputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Aligned read issued in the first cycle after reset, ready one cycle later.
      expectCompletion("read10", 32'hCAFEF00D, 1'b0);
      applyStimulus(2'b10, 32'h10, 32'h0);
      @(negedge clk);
      checkOutput("read stall N", {31'b0, stall}, 32'h1);
      tick();
      applyStimulus(2'b00, 32'h0, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      checkOutput("read stall N+1", {31'b0, stall}, 32'h1);
      checkOutput("read mem_req", {31'b0, mem_req}, 32'h1);
      checkOutput("read mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("read mem_addr", mem_addr, 32'h10);
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("read stall N+2", {31'b0, stall}, 32'h0);
      tick();

      // Write with one wait cycle; inputs change under it to prove the latch.
      expectCompletion("write20", 32'hCAFEF00D, 1'b0);
      applyStimulus(2'b01, 32'h20, 32'h12345678);
      tick();
      applyStimulus(2'b00, 32'hFFFFFFFC, 32'hAAAAAAAA);
      @(negedge clk);
      checkOutput("write mem_we", {31'b0, mem_we}, 32'h1);
      checkOutput("write mem_addr", mem_addr, 32'h20);
      checkOutput("write mem_wdata", mem_wdata, 32'h12345678);
      checkOutput("write mem_req", {31'b0, mem_req}, 32'h1);
      tick();
      mem_ready = 1'b1;
      mem_rdata = 32'h55555555;
      @(negedge clk);
      checkOutput("write mem_addr held", mem_addr, 32'h20);
      checkOutput("write stall held", {31'b0, stall}, 32'h1);
      tick();
      mem_ready = 1'b0;
      tick();

      // M=11 behaves as a write; read data must not reach DM_out.
      expectCompletion("rw24", 32'hCAFEF00D, 1'b0);
      applyStimulus(2'b11, 32'h24, 32'h0F0F0F0F);
      tick();
      applyStimulus(2'b00, 32'h0, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      checkOutput("rw mem_we", {31'b0, mem_we}, 32'h1);
      checkOutput("rw mem_wdata", mem_wdata, 32'h0F0F0F0F);
      tick();
      mem_ready = 1'b0;
      tick();

      // Misaligned read: no access, error pulse next cycle.
      expectCompletion("misalign13", 32'hCAFEF00D, 1'b1);
      applyStimulus(2'b10, 32'h13, 32'h0);
      @(negedge clk);
      checkOutput("misalign stall N", {31'b0, stall}, 32'h1);
      tick();
      applyStimulus(2'b00, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("misalign mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("misalign bus_err N+1", {31'b0, bus_err}, 32'h1);
      tick();
      @(negedge clk);
      checkOutput("misalign stall N+2", {31'b0, stall}, 32'h0);
      checkOutput("misalign bus_err N+2", {31'b0, bus_err}, 32'h0);
      tick();

      // Timeout: 15 ACCESS cycles without ready, error and zeroed data after.
      expectCompletion("timeout30", 32'h0, 1'b1);
      applyStimulus(2'b10, 32'h30, 32'h0);
      tick();
      applyStimulus(2'b00, 32'h0, 32'h0);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 1 || k == 15) begin
            checkOutput($sformatf("timeout mem_req N+%0d", k), {31'b0, mem_req}, 32'h1);
            checkOutput($sformatf("timeout bus_err N+%0d", k), {31'b0, bus_err}, 32'h0);
         end
         tick();
      end
      @(negedge clk);
      checkOutput("timeout bus_err N+16", {31'b0, bus_err}, 32'h1);
      checkOutput("timeout DM_out", DM_out, 32'h0);
      tick();
      @(negedge clk);
      checkOutput("timeout idle stall", {31'b0, stall}, 32'h0);
      checkOutput("timeout idle bus_err", {31'b0, bus_err}, 32'h0);
      tick();

      // Back-to-back reads with M held through DONE.
      expectCompletion("b2b40", 32'h11111111, 1'b0);
      expectCompletion("b2b44", 32'h22222222, 1'b0);
      c0 = completions;
      applyStimulus(2'b10, 32'h40, 32'h0);
      tick();
      mem_ready = 1'b1;
      mem_rdata = 32'h11111111;
      tick();
      mem_ready = 1'b0;
      address = 32'h44;
      @(negedge clk);
      checkOutput("b2b DONE stall", {31'b0, stall}, 32'h0);
      tick();
      @(negedge clk);
      checkOutput("b2b second request stall", {31'b0, stall}, 32'h1);
      tick();
      mem_ready = 1'b1;
      mem_rdata = 32'h22222222;
      @(negedge clk);
      checkOutput("b2b second mem_addr", mem_addr, 32'h44);
      tick();
      mem_ready = 1'b0;
      applyStimulus(2'b00, 32'h0, 32'h0);
      tick();
      tick();
      checkOutput("b2b transaction count", completions - c0, 32'd2);

      // Reset in the middle of ACCESS aborts it; later mem_ready is ignored.
      applyStimulus(2'b10, 32'h50, 32'h0);
      tick();
      applyStimulus(2'b00, 32'h0, 32'h0);
      #1 rst = 1'b1;
      #1;
      checkResetOutputs("mid-access reset");
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset DM_out", DM_out, 32'h0);
      checkOutput("post-reset mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("post-reset stall", {31'b0, stall}, 32'h0);
      tick();
      @(negedge clk);
      checkOutput("post-reset ready ignored DM_out", DM_out, 32'h0);
      checkOutput("post-reset ready ignored bus_err", {31'b0, bus_err}, 32'h0);
      mem_ready = 1'b0;
      tick();
      tick();

      checkOutput("scoreboard drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum ACCESS cycles without mem_ready before timeout.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 M  input  2  memory control from EX/MEM: bit1 MemRead, bit0 MemWrite.
REQ-005 address  input  32  byte address (EX/MEM ALU result).
REQ-006 writeData  input  32  store data.
REQ-007 DM_out  output  32  registered load data, feeds MEM/WB DM_out.
REQ-008 stall  output  1  freeze upstream pipeline registers and PC.
REQ-009 bus_err  output  1  one-cycle error pulse (misaligned or timeout).
REQ-010 mem_req  output  1  memory request, held until mem_ready.
REQ-011 mem_we  output  1  1 = write, 0 = read.
REQ-012 mem_addr  output  32  registered word address.
REQ-013 mem_wdata  output  32  registered store data.
REQ-014 mem_ready  input  1  memory completion strobe.
REQ-015 mem_rdata  input  32  read data, valid when mem_ready=1.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-017 IDLE, M==2'b00: stall=0, mem_req=0, no state change; DM_out holds.
REQ-018 IDLE, M!=0: stall=1 combinationally that cycle; address, writeData, op latched; next state ACCESS.
REQ-019 M==2'b11 SHALL be a write only; DM_out SHALL not update.
REQ-020 address[1:0]!=0 with M!=0: no memory access; bus_err=1 for one cycle; next state DONE; DM_out unchanged.
REQ-021 ACCESS: mem_req=1, stall=1; mem_addr/mem_wdata/mem_we stable from latched values.
REQ-022 ACCESS with mem_ready=1: if read, DM_out<=mem_rdata; next state DONE.
REQ-023 ACCESS wait counter SHALL increment each cycle mem_ready=0; at MAX_WAIT cycles: bus_err pulse, DM_out<=0 if read, next state DONE.
REQ-024 DONE: stall=0 for exactly one cycle; mem_req=0; M SHALL be ignored; next state IDLE.
REQ-025 Minimum latency: request cycle N, ready at N+1 -> stall high N..N+1, low at N+2, DM_out valid from N+2.
REQ-026 DM_out SHALL hold its value until the next completed read.
REQ-027 mem_ready outside ACCESS SHALL be ignored.
REQ-028 Wait counter SHALL clear on entry to ACCESS.

Reset
REQ-029 rst=1 SHALL force state IDLE, DM_out=0, stall=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, immediately.
REQ-030 rst asserted mid-ACCESS SHALL abort the transaction; no DM_out update and no bus_err.
REQ-031 First request SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-032 Package pipeline_pkg SHALL hold the FSM state encoding, M bit indices (MEMREAD=1, MEMWRITE=0) and TIMEOUT_DATA=32'h0.
REQ-033 One sub-module, mem_wait_timer (clear, enable, expired output, parameter MAX_WAIT), SHALL implement the counter.
REQ-034 Outputs SHALL connect directly to the MEM/WB register with no extra glue.

Verification
REQ-035 Read M=2'b10, address=0x10, mem_ready at N+1 with rdata=0xCAFEF00D -> stall high N,N+1; DM_out=0xCAFEF00D at N+2; bus_err=0.
REQ-036 Write M=2'b01, address=0x20, writeData=0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 in ACCESS; DM_out unchanged.
REQ-037 Read address=0x13 -> no mem_req; bus_err pulse at N+1; stall low at N+2.
REQ-038 Read, mem_ready never asserted, MAX_WAIT=15 -> bus_err after 15 ACCESS cycles, DM_out=0, FSM returns to IDLE.
REQ-039 Back-to-back reads, M held during DONE -> exactly two transactions, DONE never restarts.
REQ-040 rst asserted during ACCESS -> all outputs 0 same cycle; mem_ready after reset ignored.
